// File: rtl/dice_monitor.sv
// Passive monitor for a dice block: tracks roll phases, latches settled throws,
// counts rolls and flags sequence or range violations on the dice interface.
module dice_monitor #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic [2:0]       throw,
  output logic [2:0]       result,
  output logic             result_valid,
  output logic             double,
  output logic             seq_err,
  output logic             range_err,
  output logic [CNT_W-1:0] roll_count
);

  typedef enum logic [1:0] {IDLE, ROLLING, SETTLE} state_e;

  state_e           state_q;
  logic             btn_q;
  logic [2:0]       thr_q;
  logic [2:0]       prev_q;
  logic             chk_en_q;
  logic [2:0]       result_q;
  logic             result_valid_q;
  logic             double_q;
  logic             seq_err_q;
  logic             range_err_q;
  logic [CNT_W-1:0] roll_count_q;

  logic [2:0] exp_next_c;
  logic       thr_bad_c;
  logic       prev_bad_c;
  logic       seq_bad_c;
  logic       range_bad_c;

  // Rule checks on the sampled interface; held off for one cycle after reset.
  always_comb begin
    exp_next_c  = 3'd1;
    thr_bad_c   = (thr_q == 3'd0) || (thr_q == 3'd7);
    prev_bad_c  = (prev_q == 3'd0) || (prev_q == 3'd7);
    seq_bad_c   = 1'b0;
    range_bad_c = chk_en_q && thr_bad_c;
    if (!prev_bad_c && (prev_q != 3'd6)) begin
      exp_next_c = prev_q + 3'd1;
    end
    if (chk_en_q) begin
      case (state_q)
        ROLLING: begin
          if (btn_q && (thr_q != exp_next_c)) seq_bad_c = 1'b1;
        end
        IDLE: begin
          // An illegal value is reported by range_err only; recovery to 1 is legal.
          if (!btn_q && !thr_bad_c && (thr_q != prev_q) &&
              !(prev_bad_c && (thr_q == 3'd1))) begin
            seq_bad_c = 1'b1;
          end
        end
        default: seq_bad_c = 1'b0;
      endcase
    end
  end

  // State and outputs; the result is latched on entry so it is valid throughout SETTLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      btn_q          <= 1'b0;
      thr_q          <= 3'd0;
      prev_q         <= 3'd0;
      chk_en_q       <= 1'b0;
      result_q       <= 3'd0;
      result_valid_q <= 1'b0;
      double_q       <= 1'b0;
      seq_err_q      <= 1'b0;
      range_err_q    <= 1'b0;
      roll_count_q   <= '0;
    end else begin
      btn_q          <= button;
      thr_q          <= throw;
      prev_q         <= thr_q;
      chk_en_q       <= 1'b1;
      result_valid_q <= 1'b0;
      if (seq_bad_c)   seq_err_q   <= 1'b1;
      if (range_bad_c) range_err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (btn_q) state_q <= ROLLING;
        end
        ROLLING: begin
          if (!btn_q) begin
            state_q        <= SETTLE;
            result_q       <= thr_q;
            result_valid_q <= 1'b1;
            double_q       <= (thr_q == result_q) && (result_q != 3'd0);
            roll_count_q   <= roll_count_q + CNT_W'(1);
          end
        end
        SETTLE: begin
          state_q <= btn_q ? ROLLING : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign double       = double_q;
  assign seq_err      = seq_err_q;
  assign range_err    = range_err_q;
  assign roll_count   = roll_count_q;

endmodule

// File: tb/tb_dice_monitor.sv
// Scoreboard bench for dice_monitor: stimulus pushes expected settle results,
// a negedge monitor pops and compares whenever result_valid is seen.
module tb_dice_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic [2:0] throw;

  logic [2:0] result, result2;
  logic       result_valid, result_valid2;
  logic       double, double2;
  logic       seq_err, seq_err2;
  logic       range_err, range_err2;
  logic [7:0] roll_count;
  logic [1:0] roll_count2;

  dice_monitor #(.CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .button(button), .throw(throw),
    .result(result), .result_valid(result_valid), .double(double),
    .seq_err(seq_err), .range_err(range_err), .roll_count(roll_count)
  );

  dice_monitor #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .button(button), .throw(throw),
    .result(result2), .result_valid(result_valid2), .double(double2),
    .seq_err(seq_err2), .range_err(range_err2), .roll_count(roll_count2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] res;
    logic       dbl;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
    logic       seq;
    logic       rng;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   exp_cnt = 0;
  logic [2:0] last_res = 3'd0;
  logic exp_seq = 1'b0;
  logic exp_range = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic b, input logic [2:0] t);
    button = b;
    throw  = t;
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [2:0] r);
    exp_t e;
    exp_cnt++;
    e.res  = r;
    e.dbl  = (r == last_res) && (last_res != 3'd0);
    last_res = r;
    e.cnt8 = 8'(exp_cnt);
    e.cnt2 = 2'(exp_cnt);
    e.seq  = exp_seq;
    e.rng  = exp_range;
    e.cyc  = cyc + 2;
    q.push_back(e);
  endtask

  // n button-high samples taken from vals (LSB first), then hold final with button low.
  task automatic roll(input int n, input logic [23:0] vals, input logic [2:0] fin);
    for (int i = 0; i < n; i++) step(1'b1, vals[3*i +: 3]);
    push_exp(fin);
    repeat (3) step(1'b0, fin);
  endtask

  task automatic do_reset(input logic b, input logic [2:0] t);
    rst = 1'b1;
    step(b, t);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_double", 32'(double), 32'd0);
    chk("rst_seq_err", 32'(seq_err), 32'd0);
    chk("rst_range_err", 32'(range_err), 32'd0);
    chk("rst_roll_count", 32'(roll_count), 32'd0);
    chk("rst_roll_count_w2", 32'(roll_count2), 32'd0);
    step(1'b0, 3'd1);
    rst = 1'b0;
    exp_cnt = 0;
    last_res = 3'd0;
    exp_seq = 1'b0;
    exp_range = 1'b0;
  endtask

  // Monitor: every result_valid must match the oldest pending expectation.
  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_result_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_result", 32'(result), 32'(e.res));
        chk("sb_double", 32'(double), 32'(e.dbl));
        chk("sb_roll_count", 32'(roll_count), 32'(e.cnt8));
        chk("sb_roll_count_w2", 32'(roll_count2), 32'(e.cnt2));
        chk("sb_valid_w2", 32'(result_valid2), 32'd1);
        chk("sb_seq_err", 32'(seq_err), 32'(e.seq));
        chk("sb_range_err", 32'(range_err), 32'(e.rng));
        chk("sb_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    rst = 1'b1;
    button = 1'b0;
    throw = 3'd1;
    @(negedge clk);
    do_reset(1'b0, 3'd1);
    repeat (3) step(1'b0, 3'd1);

    // Basic roll through a 6->1 wrap, then matched and unmatched doubles.
    roll(8, {3'd2, 3'd1, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}, 3'd2);
    repeat (2) step(1'b0, 3'd2);
    roll(3, {15'd0, 3'd5, 3'd4, 3'd3}, 3'd4);
    roll(3, {15'd0, 3'd1, 3'd6, 3'd5}, 3'd4);
    roll(2, {18'd0, 3'd3, 3'd2}, 3'd5);

    // Single-cycle low between two button-high stretches.
    step(1'b1, 3'd1);
    step(1'b1, 3'd2);
    push_exp(3'd3);
    step(1'b0, 3'd3);
    step(1'b1, 3'd4);
    step(1'b1, 3'd5);
    push_exp(3'd6);
    repeat (3) step(1'b0, 3'd6);
    chk("flags_clean_seq", 32'(seq_err), 32'd0);
    chk("flags_clean_range", 32'(range_err), 32'd0);

    // Illegal settled value is still latched, range_err rises with result_valid.
    exp_range = 1'b1;
    roll(2, {18'd0, 3'd2, 3'd1}, 3'd7);
    repeat (2) step(1'b0, 3'd1);
    chk("illegal_settle_seq", 32'(seq_err), 32'd0);
    chk("illegal_settle_range", 32'(range_err), 32'd1);

    // Reset in the middle of a roll: everything clears, roll not counted.
    step(1'b1, 3'd1);
    step(1'b1, 3'd2);
    step(1'b1, 3'd3);
    do_reset(1'b1, 3'd4);
    repeat (4) step(1'b0, 3'd1);
    chk("post_rst_roll_count", 32'(roll_count), 32'd0);
    chk("post_rst_result", 32'(result), 32'd0);

    // Illegal value while idle, then recovery to 1.
    step(1'b0, 3'd7);
    repeat (3) step(1'b0, 3'd1);
    chk("idle7_range", 32'(range_err), 32'd1);
    chk("idle7_seq", 32'(seq_err), 32'd0);

    // Skipped value during a roll: seq_err one cycle later and sticky.
    do_reset(1'b0, 3'd1);
    repeat (3) step(1'b0, 3'd1);
    step(1'b1, 3'd2);
    step(1'b1, 3'd3);
    step(1'b1, 3'd5);
    chk("seq_not_yet", 32'(seq_err), 32'd0);
    exp_seq = 1'b1;
    push_exp(3'd5);
    step(1'b0, 3'd5);
    chk("seq_next_cycle", 32'(seq_err), 32'd1);
    repeat (6) step(1'b0, 3'd5);
    chk("seq_sticky", 32'(seq_err), 32'd1);
    chk("seq_range_clear", 32'(range_err), 32'd0);

    repeat (4) step(1'b0, 3'd5);
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dice_monitor.md
DICE_MONITOR -- requirements
Module: dice_monitor

Interface
REQ-001 Parameter: CNT_W, default 8, width of the roll counter.
REQ-002 Port: clk  input  1  system clock, all logic on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: button  input  1  same button signal that drives the dice block.
REQ-005 Port: throw  input  3  dice value from the dice block, legal range 1-6.
REQ-006 Port: result  output  3  last settled throw value.
REQ-007 Port: result_valid  output  1  one-cycle pulse when result updates.
REQ-008 Port: double  output  1  high when the latest result equals the previous result.
REQ-009 Port: seq_err  output  1  sticky flag for a dice sequence violation.
REQ-010 Port: range_err  output  1  sticky flag for an illegal throw value (0 or 7).
REQ-011 Port: roll_count  output  CNT_W  number of completed rolls.

Function
REQ-012 The block is a passive reader of the dice interface and SHALL never drive button or throw.
REQ-013 It SHALL register button and throw once per clock and compare the sampled throw with the previous cycle's sample (prev).
REQ-014 The FSM SHALL have three states: IDLE, ROLLING and SETTLE.
REQ-015 IDLE -> ROLLING when the sampled button is 1.
REQ-016 ROLLING stays in ROLLING while button is 1, and goes to SETTLE on the first sampled button of 0.
REQ-017 SETTLE -> IDLE after exactly one cycle, or -> ROLLING if button is 1 again in that cycle.
REQ-018 Expected-next rule while in ROLLING with button=1:
- throw SHALL equal prev+1 for prev in 1-5;
- throw SHALL equal 1 for prev=6;
- throw SHALL equal 1 for prev=0 or 7.
- A mismatch SHALL set seq_err on the following edge.
REQ-019 Hold rule in IDLE with button=0: throw SHALL equal prev, else seq_err is set.
- Exception: a prev of 0 or 7 recovering to 1 is legal.
REQ-020 range_err SHALL set when the sampled throw is 0 or 7 in any state other than the first cycle after reset.
REQ-021 In SETTLE the block SHALL:
- latch result = sampled throw;
- pulse result_valid for one cycle;
- increment roll_count.
REQ-022 result SHALL change only on a result_valid cycle; result_valid SHALL appear 2 cycles after button is seen low at the input.
REQ-023 double SHALL be set with result_valid if the new result equals the old result and the old result is nonzero; it SHALL otherwise hold until the next result_valid.
REQ-024 roll_count SHALL wrap from 2^CNT_W-1 to 0 without setting any flag.
REQ-025 seq_err and range_err SHALL be sticky and clear only on rst.
REQ-026 An illegal throw in SETTLE SHALL still be latched to result, with range_err set in the same cycle as result_valid.
REQ-027 If button toggles 1-0-1 with a single-cycle low, the block SHALL pass through SETTLE, count the roll and return to ROLLING.

Reset
REQ-028 rst=1 on a clock edge SHALL apply these values, regardless of state (including mid-roll):
- state = IDLE, result = 0, result_valid = 0, double = 0;
- seq_err = 0, range_err = 0, roll_count = 0, prev = 0.
REQ-029 Sequence and range checks SHALL be suppressed for the first cycle after rst deasserts.
REQ-030 A roll in progress when reset asserts SHALL NOT be counted.

Verification
REQ-031 Reset, then button=1 for 8 cycles with throw 1,2,3,4,5,6,1,2, then button=0 and throw held at 2 -> result=2 with result_valid 2 cycles later, roll_count=1, seq_err=0, range_err=0.
REQ-032 During a roll, throw goes 3 then 5 -> seq_err=1 one cycle later and stays 1 until rst.
REQ-033 throw=7 while idle -> range_err=1 and seq_err=0 when the next throw is 1.
REQ-034 Two rolls both ending on 4 -> double=1 on the second result_valid; a third roll ending on 5 -> double=0.
REQ-035 CNT_W=2, five rolls -> roll_count goes 1,2,3,0,1 with no error flags.
REQ-036 rst asserted in ROLLING -> all outputs 0 next cycle, and the interrupted roll is not counted.
